// File: rtl/seq_addsub.sv
// seq_addsub: digit-serial add/subtract with signed/unsigned and saturate/wrap result modes.
// Optional SEQ_ADDSUB_ACC_EN adds an acc input that feeds the previous out back as operand A.
//
// state | meaning
// IDLE  | waiting for start; operands and mode bits latched on start
// EXT   | extend latched operands to EXT_W, invert B and set carry-in for subtract
// CALC  | add one CHUNK slice per edge, LSB slice first, carry registered
// SAT   | range-check the full sum, clamp or wrap, publish out/ovf with done
module seq_addsub #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 5,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             sub,
    input  logic             is_signed,
    input  logic             sat,
`ifdef SEQ_ADDSUB_ACC_EN
    input  logic             acc,
`endif
    output logic [OUT_W-1:0] out,
    output logic             ovf,
    output logic             running,
    output logic             done
);

    localparam int MAX_W = (IN_W + 1 > OUT_W) ? IN_W + 1 : OUT_W;
    localparam int EXT_W = ((MAX_W + CHUNK - 1) / CHUNK) * CHUNK;
    localparam int N     = EXT_W / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int CMP_W = EXT_W + 2;

    typedef enum logic [1:0] {IDLE, EXT, CALC, SAT} state_t;

    state_t             state_q;
    logic [IN_W-1:0]    a_raw_q, b_raw_q;
    logic               sub_q, signed_q, sat_q;
    logic [EXT_W-1:0]   a_q, b_q, sum_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OUT_W-1:0]   out_q;
    logic               ovf_q, running_q, done_q;

    logic [IN_W-1:0]    a_sel;
    logic [EXT_W-1:0]   a_ext, b_ext, sum_d;
    logic [CHUNK:0]     slice;
    logic signed [CMP_W-1:0] s_val, hi_v, lo_v, one_v;
    logic [OUT_W-1:0]   out_d;
    logic               ovf_d;

`ifdef SEQ_ADDSUB_ACC_EN
    localparam int AW = (IN_W > OUT_W) ? IN_W : OUT_W;
    logic [AW-1:0] out_ext;
    always_comb begin
        if (is_signed) out_ext = AW'($signed(out_q));
        else           out_ext = AW'(out_q);
        a_sel = acc ? IN_W'(out_ext) : a;
    end
`else
    assign a_sel = a;
`endif

    always_comb begin
        if (signed_q) begin
            a_ext = EXT_W'($signed(a_raw_q));
            b_ext = EXT_W'($signed(b_raw_q));
        end else begin
            a_ext = EXT_W'(a_raw_q);
            b_ext = EXT_W'(b_raw_q);
        end
    end

    assign slice = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    // new slice enters at the top; after N shifts the LSB slice has reached bit 0
    assign sum_d = EXT_W'({slice[CHUNK-1:0], sum_q} >> CHUNK);

    always_comb begin
        one_v = CMP_W'(1);
        if (signed_q || sub_q) s_val = CMP_W'($signed(sum_q));
        else                   s_val = CMP_W'(sum_q);
        if (signed_q) begin
            hi_v = (one_v <<< (OUT_W - 1)) - one_v;
            lo_v = -(one_v <<< (OUT_W - 1));
        end else begin
            hi_v = (one_v <<< OUT_W) - one_v;
            lo_v = '0;
        end
        ovf_d = (s_val > hi_v) || (s_val < lo_v);
        if (sat_q && (s_val > hi_v))      out_d = OUT_W'(hi_v);
        else if (sat_q && (s_val < lo_v)) out_d = OUT_W'(lo_v);
        else                              out_d = OUT_W'(s_val);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
            sub_q     <= 1'b0;
            signed_q  <= 1'b0;
            sat_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_raw_q   <= a_sel;
                        b_raw_q   <= b;
                        sub_q     <= sub;
                        signed_q  <= is_signed;
                        sat_q     <= sat;
                        running_q <= 1'b1;
                        state_q   <= EXT;
                    end
                end
                EXT: begin
                    a_q     <= a_ext;
                    b_q     <= sub_q ? ~b_ext : b_ext;
                    carry_q <= sub_q;
                    sum_q   <= '0;
                    cnt_q   <= CNT_W'(N - 1);
                    state_q <= CALC;
                end
                CALC: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    sum_q   <= sum_d;
                    carry_q <= slice[CHUNK];
                    if (cnt_q == '0) state_q <= SAT;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                SAT: begin
                    out_q     <= out_d;
                    ovf_q     <= ovf_d;
                    done_q    <= 1'b1;
                    running_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out     = out_q;
    assign ovf     = ovf_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: three seq_addsub configurations driven in parallel and checked against an
// integer-arithmetic model of the add/subtract, range and clamp/wrap rules.
module tb_seq_addsub;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic sub = 1'b0, is_signed = 1'b0, sat = 1'b0;
`ifdef SEQ_ADDSUB_ACC_EN
    logic acc = 1'b0;
`endif

    logic [4:0] out0;
    logic [2:0] out1;
    logic [3:0] out2;
    logic [NI-1:0] ovf_v, run_v, done_v;
    int out_v [NI];

    int n_checks = 0;
    int n_fail = 0;
    int last_out [NI];

    always #5 clk = ~clk;

    seq_addsub #(.IN_W(4), .OUT_W(5), .CHUNK(2)) u_d (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .sub(sub),
        .is_signed(is_signed), .sat(sat),
`ifdef SEQ_ADDSUB_ACC_EN
        .acc(acc),
`endif
        .out(out0), .ovf(ovf_v[0]), .running(run_v[0]), .done(done_v[0]));

    seq_addsub #(.IN_W(4), .OUT_W(3), .CHUNK(1)) u_w3 (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .sub(sub),
        .is_signed(is_signed), .sat(sat),
`ifdef SEQ_ADDSUB_ACC_EN
        .acc(acc),
`endif
        .out(out1), .ovf(ovf_v[1]), .running(run_v[1]), .done(done_v[1]));

    seq_addsub #(.IN_W(4), .OUT_W(4), .CHUNK(3)) u_c3 (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .sub(sub),
        .is_signed(is_signed), .sat(sat),
`ifdef SEQ_ADDSUB_ACC_EN
        .acc(acc),
`endif
        .out(out2), .ovf(ovf_v[2]), .running(run_v[2]), .done(done_v[2]));

    always_comb begin
        out_v[0] = int'(out0);
        out_v[1] = int'(out1);
        out_v[2] = int'(out2);
    end

    function automatic int ow(input int k);
        return (k == 0) ? 5 : (k == 1) ? 3 : 4;
    endfunction

    function automatic int chunk_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 3;
    endfunction

    // done arrives N+2 edges after the start edge, N = ceil(max(IN_W+1,OUT_W)/CHUNK)
    function automatic int exp_lat(input int k);
        int w;
        w = (ow(k) > 5) ? ow(k) : 5;
        return (w + chunk_of(k) - 1) / chunk_of(k) + 2;
    endfunction

    function automatic int to_val(input int raw, input int w, input int sg);
        int v;
        v = raw & ((1 << w) - 1);
        if (sg != 0 && ((v >> (w - 1)) & 1) == 1) v -= (1 << w);
        return v;
    endfunction

    task automatic ref_op(input int outw, input int ra, input int rb, input int isub,
                          input int isg, input int isat, output int eo, output int ev);
        int av, bv, s, hi, lo, r;
        av = to_val(ra, 4, isg);
        bv = to_val(rb, 4, isg);
        s  = (isub != 0) ? av - bv : av + bv;
        if (isg != 0) begin
            hi = (1 << (outw - 1)) - 1;
            lo = -(1 << (outw - 1));
        end else begin
            hi = (1 << outw) - 1;
            lo = 0;
        end
        ev = (s > hi || s < lo) ? 1 : 0;
        r  = s;
        if (isat != 0) r = (s > hi) ? hi : ((s < lo) ? lo : s);
        eo = r & ((1 << outw) - 1);
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_out%0d", tag, k), out_v[k], 0);
            check($sformatf("%s_ovf%0d", tag, k), int'(ovf_v[k]), 0);
            check($sformatf("%s_run%0d", tag, k), int'(run_v[k]), 0);
            check($sformatf("%s_done%0d", tag, k), int'(done_v[k]), 0);
        end
    endtask

    task automatic do_op(input int ia, input int ib, input int isub, input int isg,
                         input int isat, input int iacc, input bit disturb);
        bit [NI-1:0] got;
        int lat [NI];
        int ro [NI];
        int rv [NI];
        int runs, nd0, eo, ev, aa;
        @(negedge clk);
        a = 4'(ia); b = 4'(ib); sub = 1'(isub); is_signed = 1'(isg); sat = 1'(isat);
`ifdef SEQ_ADDSUB_ACC_EN
        acc = 1'(iacc);
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        runs = run_v[0] ? 1 : 0;
        nd0 = 0;
        got = '0;
        for (int k = 0; k < NI; k++) begin lat[k] = -1; ro[k] = -1; rv[k] = -1; end
        for (int e = 1; e <= 20 && got != {NI{1'b1}}; e++) begin
            @(posedge clk); #1;
            if (run_v[0]) runs++;
            if (done_v[0]) nd0++;
            for (int k = 0; k < NI; k++)
                if (done_v[k] && !got[k]) begin
                    got[k] = 1'b1; lat[k] = e; ro[k] = out_v[k]; rv[k] = int'(ovf_v[k]);
                end
            if (disturb && e == 2) begin
                start = 1'b1; a = 4'($urandom); b = 4'($urandom);
                sub = ~sub; is_signed = ~is_signed; sat = ~sat;
            end
            if (disturb && e == 3) start = 1'b0;
        end
        for (int k = 0; k < NI; k++) begin
            aa = (iacc != 0) ? (to_val(last_out[k], ow(k), isg) & 15) : ia;
            ref_op(ow(k), aa, ib, isub, isg, isat, eo, ev);
            check($sformatf("out%0d a=%0d b=%0d m=%0d%0d%0d", k, aa, ib, isub, isg, isat), ro[k], eo);
            check($sformatf("ovf%0d a=%0d b=%0d m=%0d%0d%0d", k, aa, ib, isub, isg, isat), rv[k], ev);
            check($sformatf("lat%0d", k), lat[k], exp_lat(k));
            last_out[k] = eo;
        end
        check("run_cycles0", runs, exp_lat(0));
        check("done_pulses0", nd0, 1);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) last_out[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        do_op(15, 15, 0, 0, 0, 0, 1'b0);
        do_op(7, 7, 0, 1, 1, 0, 1'b0);
        do_op(7, 7, 0, 1, 0, 0, 1'b0);
        do_op(3, 5, 1, 0, 1, 0, 1'b0);
        do_op(3, 5, 1, 0, 0, 0, 1'b0);
        do_op(8, 8, 0, 1, 1, 0, 1'b0);
        do_op(8, 7, 1, 1, 0, 0, 1'b0);
        do_op(15, 15, 0, 0, 0, 0, 1'b1);
        do_op(9, 12, 1, 1, 1, 0, 1'b1);

        // abort mid-CALC: outputs clear at once and no done follows
        @(negedge clk);
        a = 4'd6; b = 4'd6; sub = 1'b0; is_signed = 1'b0; sat = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_idle_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("abort_hold");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < NI; k++) last_out[k] = 0;
        do_op(1, 2, 0, 0, 0, 0, 1'b0);

`ifdef SEQ_ADDSUB_ACC_EN
        do_op(5, 3, 0, 0, 0, 0, 1'b0);
        do_op(9, 4, 0, 0, 0, 1, 1'b0);
        do_op(2, 7, 1, 1, 1, 1, 1'b0);
        do_op(0, 3, 0, 1, 0, 1, 1'b0);
`endif

        for (int i = 0; i < 300; i++)
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), 0, ($urandom_range(0, 7) == 0));

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int m = 0; m < 8; m++)
                    do_op(ia, ib, m & 1, (m >> 1) & 1, (m >> 2) & 1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
